dpram32x32_cb: RTL and testbench



---
 rtl/dpram32x32_cb_if.sv | 20 ++
 rtl/dpram32x32_cb.sv | 59 +++++
 tb/tb_dpram32x32_cb.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/dpram32x32_cb_if.sv
// Bus bundle for the two-port 32x32 RAM: per-port address, data, active-low controls and read data.
interface dpram32x32_cb_if;
  logic [4:0]  A1, A2;
  logic [31:0] I1, I2;
  logic        CEB1, CSB1, WEB1, OEB1;
  logic        CEB2, CSB2, WEB2, OEB2;
  logic [31:0] O1, O2;

  modport master (
    output A1, I1, CEB1, CSB1, WEB1, OEB1,
    output A2, I2, CEB2, CSB2, WEB2, OEB2,
    input  O1, O2
  );

  modport slave (
    input  A1, I1, CEB1, CSB1, WEB1, OEB1,
    input  A2, I2, CEB2, CSB2, WEB2, OEB2,
    output O1, O2
  );
endinterface

// File: rtl/dpram32x32_cb.sv
// 32x32 dual-port synchronous RAM, registered reads, port 1 wins same-address write collisions.
// Optional DPRAM_BYPASS_EN: a cross-port read of a word being written returns the new data.
module dpram32x32_cb #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32
) (
  input  logic           CLK,
  input  logic           RST,
  dpram32x32_cb_if.slave bus
);
  localparam int NUM_PORTS = 2;

  logic [NUM_PORTS-1:0][ADDR_W-1:0] addr;
  logic [NUM_PORTS-1:0][DATA_W-1:0] wdat;
  logic [NUM_PORTS-1:0]             act, web, wr, rd;
  logic                             wr2_keep;

  logic [DATA_W-1:0]                mem_q [DEPTH];
  logic [NUM_PORTS-1:0][DATA_W-1:0] r_q, r_d;

  assign addr = {bus.A2, bus.A1};
  assign wdat = {bus.I2, bus.I1};
  assign web  = {bus.WEB2, bus.WEB1};
  assign act  = {~bus.CEB2 & ~bus.CSB2, ~bus.CEB1 & ~bus.CSB1};
  assign wr   = act & ~web;
  assign rd   = act & web;

  // Port 2 loses a same-address write collision.
  assign wr2_keep = wr[1] & ~(wr[0] & (addr[0] == addr[1]));

  always_comb begin
    r_d = r_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (rd[p]) begin
        r_d[p] = mem_q[addr[p]];
`ifdef DPRAM_BYPASS_EN
        // A reading port is not writing, so only the other port can collide here.
        if (wr[1-p] && (addr[1-p] == addr[p])) r_d[p] = wdat[1-p];
`endif
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      r_q <= '0;
    end else begin
      if (wr[0])    mem_q[addr[0]] <= wdat[0];
      if (wr2_keep) mem_q[addr[1]] <= wdat[1];
      r_q <= r_d;
    end
  end

  // Output enable only masks the register, never the access.
  assign bus.O1 = bus.OEB1 ? '0 : r_q[0];
  assign bus.O2 = bus.OEB2 ? '0 : r_q[1];
endmodule

// File: tb/tb_dpram32x32_cb.sv
// Scoreboard bench for dpram32x32_cb: an array model queues expected read data, a monitor checks O1/O2.
module tb_dpram32x32_cb;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  dpram32x32_cb_if bus();
  dpram32x32_cb dut (.CLK(CLK), .RST(RST), .bus(bus));

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  logic [31:0] mdl [32];
  logic [31:0] q1 [$];
  logic [31:0] q2 [$];
  logic [31:0] cur1 = '0;
  logic [31:0] cur2 = '0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endfunction

  // Monitor: a read accepted at this edge becomes the register content the port shows.
  always @(posedge CLK) begin
    if (RST) begin
      cur1 = '0;
      cur2 = '0;
    end else begin
      if (!bus.CEB1 && !bus.CSB1 && bus.WEB1) begin
        if (q1.size() == 0) begin
          total++; bad++;
          $display("FAIL q1_underflow got=empty want=entry t=%0t", $time);
        end else cur1 = q1.pop_front();
      end
      if (!bus.CEB2 && !bus.CSB2 && bus.WEB2) begin
        if (q2.size() == 0) begin
          total++; bad++;
          $display("FAIL q2_underflow got=empty want=entry t=%0t", $time);
        end else cur2 = q2.pop_front();
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("O1", bus.O1, bus.OEB1 ? 32'h0 : cur1);
      chk("O2", bus.O2, bus.OEB2 ? 32'h0 : cur2);
    end
  end

  task automatic p1(bit en, bit we, bit oe, logic [4:0] a, logic [31:0] d);
    bus.CEB1 = !en; bus.CSB1 = !en; bus.WEB1 = !we; bus.OEB1 = !oe;
    bus.A1 = a; bus.I1 = d;
  endtask

  task automatic p2(bit en, bit we, bit oe, logic [4:0] a, logic [31:0] d);
    bus.CEB2 = !en; bus.CSB2 = !en; bus.WEB2 = !we; bus.OEB2 = !oe;
    bus.A2 = a; bus.I2 = d;
  endtask

  task automatic idle();
    p1(1'b0, 1'b0, 1'b1, 5'h0, 32'h0);
    p2(1'b0, 1'b0, 1'b1, 5'h0, 32'h0);
  endtask

  // Reference: reads see the memory as it was before this cycle, then writes land, port 1 last.
  task automatic step();
    bit w1, w2, r1, r2;
    logic [31:0] v;
    w1 = !bus.CEB1 && !bus.CSB1 && !bus.WEB1;
    r1 = !bus.CEB1 && !bus.CSB1 &&  bus.WEB1;
    w2 = !bus.CEB2 && !bus.CSB2 && !bus.WEB2;
    r2 = !bus.CEB2 && !bus.CSB2 &&  bus.WEB2;
    if (RST) begin
      foreach (mdl[i]) mdl[i] = '0;
    end else begin
      if (r1) begin
        v = mdl[bus.A1];
`ifdef DPRAM_BYPASS_EN
        if (w2 && bus.A2 == bus.A1) v = bus.I2;
`endif
        q1.push_back(v);
      end
      if (r2) begin
        v = mdl[bus.A2];
`ifdef DPRAM_BYPASS_EN
        if (w1 && bus.A1 == bus.A2) v = bus.I1;
`endif
        q2.push_back(v);
      end
      if (w2) mdl[bus.A2] = bus.I2;
      if (w1) mdl[bus.A1] = bus.I1;
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    idle();
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
    chk_en = 1'b1;

    // Random traffic on a narrow address window to provoke collisions, with rare resets.
    repeat (300) begin
      p1($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
         5'($urandom_range(0, 7)), $urandom);
      p2($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
         5'($urandom_range(0, 7)), $urandom);
      RST = ($urandom_range(0, 59) == 0);
      step();
    end
    RST = 1'b0;

    // Writes everywhere, then one reset cycle, then sweep both ports.
    for (int i = 0; i < 32; i++) begin
      p1(1'b1, 1'b1, 1'b0, 5'(i), $urandom);
      p2(1'b1, 1'b0, 1'b0, 5'(31 - i), 32'h0);
      step();
    end
    p1(1'b1, 1'b0, 1'b0, 5'h2, 32'h0);
    p2(1'b1, 1'b0, 1'b0, 5'h9, 32'h0);
    step();
    idle();
    RST = 1'b1;
    step();
    RST = 1'b0;
    for (int i = 0; i < 32; i++) begin
      p1(1'b1, 1'b0, 1'b1, 5'(i), 32'h0);
      p2(1'b1, 1'b0, 1'b1, 5'(31 - i), 32'h0);
      step();
    end

    // Basic write then read on both ports.
    idle();
    p1(1'b1, 1'b1, 1'b1, 5'h0F, 32'h7B); step();
    p1(1'b1, 1'b1, 1'b1, 5'h0A, 32'h67); step();
    p1(1'b1, 1'b0, 1'b1, 5'h0F, 32'h0);
    p2(1'b1, 1'b0, 1'b1, 5'h0F, 32'h0);  step();
    p1(1'b1, 1'b0, 1'b1, 5'h0A, 32'h0);
    p2(1'b0, 1'b0, 1'b1, 5'h0, 32'h0);   step();

    // Gated writes must not land; output enable masks without disturbing the register.
    p1(1'b1, 1'b1, 1'b1, 5'h05, 32'hDEADBEEF); bus.CSB1 = 1'b1; step();
    p1(1'b1, 1'b1, 1'b1, 5'h05, 32'hDEADBEEF); bus.CEB1 = 1'b1; step();
    p1(1'b1, 1'b0, 1'b1, 5'h05, 32'h0); step();
    p1(1'b1, 1'b1, 1'b1, 5'h05, 32'h12345678); step();
    p1(1'b1, 1'b0, 1'b1, 5'h05, 32'h0); step();
    p1(1'b0, 1'b0, 1'b0, 5'h0, 32'h0); step(); step();
    p1(1'b0, 1'b0, 1'b1, 5'h0, 32'h0); step();

    // Same-address write collision, then read/write cross-port collision.
    p1(1'b1, 1'b1, 1'b1, 5'h1F, 32'h11111111);
    p2(1'b1, 1'b1, 1'b1, 5'h1F, 32'h22222222); step();
    p1(1'b1, 1'b0, 1'b1, 5'h1F, 32'h0);
    p2(1'b1, 1'b0, 1'b1, 5'h1F, 32'h0);        step();
    p1(1'b1, 1'b1, 1'b1, 5'h03, 32'hAAAA0000);
    p2(1'b0, 1'b0, 1'b1, 5'h0, 32'h0);         step();
    p1(1'b1, 1'b1, 1'b1, 5'h03, 32'h5555FFFF);
    p2(1'b1, 1'b0, 1'b1, 5'h03, 32'h0);        step();
    p1(1'b0, 1'b0, 1'b1, 5'h0, 32'h0);
    p2(1'b1, 1'b0, 1'b1, 5'h03, 32'h0);        step();

    // Streaming: port 1 writes i*3 to i while port 2 trails one address behind.
    for (int i = 0; i < 32; i++) begin
      p1(1'b1, 1'b1, 1'b1, 5'(i), 32'(i * 3));
      p2(1'b1, 1'b0, 1'b1, 5'(i - 1), 32'h0);
      step();
    end
    p2(1'b1, 1'b0, 1'b1, 5'h1F, 32'h0);
    p1(1'b0, 1'b0, 1'b1, 5'h0, 32'h0);
    step();

    idle();
    step();
    step();
    chk_en = 1'b0;
    chk("q1_left", 32'(q1.size()), 32'h0);
    chk("q2_left", 32'(q2.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
